// File: rtl/b1_report_sched.sv
// Purpose: snapshots the BOC/TMBOC tracking channels on a PPS epoch and serialises each into a 19-byte framed report.
// Latency: PPS sampled at edge N -> SNAP after N -> header byte valid after edge N+1; back-to-back bytes while rx_ready is high.
// Backpressure: valid/ready byte interface; the byte holds until taken and the frame stalls on rx_ready low; a PPS arriving while busy is dropped and counted.
//
// Ports:
//   rx_clk, rx_rst        clock, asynchronous active-high reset
//   rx_pps                PPS epoch pulse (already synchronised)
//   rx_start, rx_stop     arm / disarm pulses (stop wins when both are high)
//   rx_ch_en[1:0]         channel mask, [0]=BOC [1]=TMBOC
//   rx_boc_*, rx_tmboc_*  live channel state (carrier NCO, code NCO, chip index, prompt I/Q)
//   tx_byte, tx_valid     byte stream towards the UART, accepted when rx_ready is high
//   tx_busy               report in progress (snapshot through the last gap)
//   tx_frame_done         pulses while a frame's checksum byte transfers
//   tx_ovf, tx_ovf_cnt    dropped-PPS pulse and saturating count
module b1_report_sched #(
    parameter logic [7:0] HDR     = 8'hA5,
    parameter int         GAP_CYC = 16
) (
    input  logic        rx_clk,
    input  logic        rx_rst,
    input  logic        rx_pps,
    input  logic        rx_start,
    input  logic        rx_stop,
    input  logic [1:0]  rx_ch_en,
    input  logic [31:0] rx_boc_car_nco,
    input  logic [31:0] rx_boc_prn_nco,
    input  logic [11:0] rx_boc_prn_phs,
    input  logic [23:0] rx_boc_bbP_real,
    input  logic [23:0] rx_boc_bbP_imag,
    input  logic [31:0] rx_tmboc_car_nco,
    input  logic [31:0] rx_tmboc_prn_nco,
    input  logic [11:0] rx_tmboc_prn_phs,
    input  logic [23:0] rx_tmboc_bbP_real,
    input  logic [23:0] rx_tmboc_bbP_imag,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        rx_ready,
    output logic        tx_busy,
    output logic        tx_frame_done,
    output logic        tx_ovf,
    output logic [7:0]  tx_ovf_cnt
);

    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {IDLE, SNAP, SEND, GAP} state_t;

    state_t         state, state_nxt;
    logic [4:0]     k, k_nxt;             // byte index within the frame
    logic [GW-1:0]  gap_cnt, gap_nxt;
    logic           cur, cur_nxt;         // channel being sent: 0=BOC 1=TMBOC
    logic           armed;
    logic [1:0]     en_q;

    // Snapshot registers, index 0=BOC 1=TMBOC
    logic [31:0]    car_q [2];
    logic [31:0]    prn_q [2];
    logic [11:0]    phs_q [2];
    logic [23:0]    re_q  [2];
    logic [23:0]    im_q  [2];

    logic           xfer;
    logic           last_byte;
    logic           pps_take;
    logic           overrun;

    assign tx_valid      = (state == SEND);
    assign tx_busy       = (state != IDLE);
    assign xfer          = tx_valid & rx_ready;
    assign last_byte     = (k == 5'd18);
    assign tx_frame_done = xfer & last_byte;
    assign pps_take      = rx_pps & armed & (|rx_ch_en) & (state == IDLE);
    assign overrun       = rx_pps & armed & (state != IDLE);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state   <= IDLE;
            k       <= '0;
            gap_cnt <= '0;
            cur     <= 1'b0;
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            gap_cnt <= gap_nxt;
            cur     <= cur_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        gap_nxt   = gap_cnt;
        cur_nxt   = cur;
        case (state)
            IDLE: begin
                if (pps_take) state_nxt = SNAP;
            end
            SNAP: begin
                state_nxt = SEND;
                k_nxt     = '0;
                cur_nxt   = ~rx_ch_en[0];   // BOC first when enabled
            end
            SEND: begin
                if (xfer) begin
                    if (last_byte) begin
                        state_nxt = GAP;
                        gap_nxt   = '0;
                    end else begin
                        k_nxt = k + 5'd1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 1)) begin
                    // A disarm during the first frame suppresses the TMBOC frame.
                    if (!cur && en_q[1] && armed && !rx_stop) begin
                        state_nxt = SEND;
                        k_nxt     = '0;
                        cur_nxt   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Arming, snapshot and overrun bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            armed      <= 1'b0;
            en_q       <= '0;
            tx_ovf     <= 1'b0;
            tx_ovf_cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                car_q[i] <= '0;
                prn_q[i] <= '0;
                phs_q[i] <= '0;
                re_q[i]  <= '0;
                im_q[i]  <= '0;
            end
        end else begin
            if (rx_stop)       armed <= 1'b0;
            else if (rx_start) armed <= 1'b1;

            if (state == SNAP) begin
                en_q     <= rx_ch_en;
                car_q[0] <= rx_boc_car_nco;
                prn_q[0] <= rx_boc_prn_nco;
                phs_q[0] <= rx_boc_prn_phs;
                re_q[0]  <= rx_boc_bbP_real;
                im_q[0]  <= rx_boc_bbP_imag;
                car_q[1] <= rx_tmboc_car_nco;
                prn_q[1] <= rx_tmboc_prn_nco;
                phs_q[1] <= rx_tmboc_prn_phs;
                re_q[1]  <= rx_tmboc_bbP_real;
                im_q[1]  <= rx_tmboc_bbP_imag;
            end

            tx_ovf <= overrun;
            if (overrun && tx_ovf_cnt != 8'hFF) tx_ovf_cnt <= tx_ovf_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly: the whole frame is built from the frozen snapshot and
    // the current byte is picked by shifting it left by k bytes.
    // ------------------------------------------------------------------
    logic [7:0]   id_s;
    logic [7:0]   chk_s;
    logic [135:0] body;
    logic [151:0] frame;
    logic [151:0] frame_sh;

    always_comb begin
        id_s  = cur ? 8'h02 : 8'h01;
        body  = {id_s, car_q[cur], prn_q[cur], 4'h0, phs_q[cur], re_q[cur], im_q[cur]};
        chk_s = '0;
        for (int i = 0; i < 17; i++) chk_s = chk_s ^ body[8*i +: 8];
        frame    = {HDR, body, chk_s};
        frame_sh = frame << {k, 3'b000};
    end

    assign tx_byte = (state == SEND) ? frame_sh[151:144] : 8'h00;

endmodule

// File: tb/tb_b1_report_sched.sv
// Scoreboard bench for b1_report_sched: stimulus pushes expected bytes, an independent monitor pops and compares.
module tb_b1_report_sched;

    localparam logic [7:0] HDR     = 8'hA5;
    localparam int         GAP_CYC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pps = 1'b0, start = 1'b0, stop = 1'b0, ready = 1'b0;
    logic [1:0]  ch_en = 2'b00;
    logic [31:0] car [2], prn [2];
    logic [11:0] phs [2];
    logic [23:0] re [2], im [2];

    logic [7:0]  tx_byte, tx_ovf_cnt;
    logic        tx_valid, tx_busy, tx_frame_done, tx_ovf;

    always #5 clk = ~clk;

    b1_report_sched #(.HDR(HDR), .GAP_CYC(GAP_CYC)) dut (
        .rx_clk(clk), .rx_rst(rst), .rx_pps(pps), .rx_start(start), .rx_stop(stop),
        .rx_ch_en(ch_en),
        .rx_boc_car_nco(car[0]), .rx_boc_prn_nco(prn[0]), .rx_boc_prn_phs(phs[0]),
        .rx_boc_bbP_real(re[0]), .rx_boc_bbP_imag(im[0]),
        .rx_tmboc_car_nco(car[1]), .rx_tmboc_prn_nco(prn[1]), .rx_tmboc_prn_phs(phs[1]),
        .rx_tmboc_bbP_real(re[1]), .rx_tmboc_bbP_imag(im[1]),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .rx_ready(ready), .tx_busy(tx_busy),
        .tx_frame_done(tx_frame_done), .tx_ovf(tx_ovf), .tx_ovf_cnt(tx_ovf_cnt)
    );

    typedef struct {
        logic [7:0] d;
        bit         last;
        bit         follows;   // header of a TMBOC frame that directly follows BOC in one report
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   ready_mode = 0;      // 0: always ready, 1: random, 2: never ready
    bit   m_armed = 0;
    int   exp_ovf = 0, ovf_events = 0, ovf_seen = 0;
    int   frames_seen = 0, bytes_in_frame = 0;

    // Values the model expects to see in the next report
    logic [31:0] s_car [2], s_prn [2];
    logic [11:0] s_phs [2];
    logic [23:0] s_re [2], s_im [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame from the field rules, MSB first, XOR checksum over ID..last imag byte.
    function automatic void push_frame(input int ch, input bit follows);
        logic [7:0] b [19];
        logic [7:0] x;
        b[0] = HDR;
        b[1] = (ch == 0) ? 8'h01 : 8'h02;
        for (int i = 0; i < 4; i++) begin
            b[2+i] = 8'(s_car[ch] >> (24 - 8*i));
            b[6+i] = 8'(s_prn[ch] >> (24 - 8*i));
        end
        b[10] = {4'h0, s_phs[ch][11:8]};
        b[11] = s_phs[ch][7:0];
        for (int i = 0; i < 3; i++) begin
            b[12+i] = 8'(s_re[ch] >> (16 - 8*i));
            b[15+i] = 8'(s_im[ch] >> (16 - 8*i));
        end
        x = 8'h00;
        for (int i = 1; i <= 17; i++) x = x ^ b[i];
        b[18] = x;
        for (int i = 0; i < 19; i++) exp_q.push_back('{b[i], (i == 18), (follows && i == 0)});
    endfunction

    task automatic scramble();
        for (int c = 0; c < 2; c++) begin
            car[c] = $urandom;
            prn[c] = $urandom;
            phs[c] = 12'($urandom);
            re[c]  = 24'($urandom);
            im[c]  = 24'($urandom);
        end
    endtask

    task automatic pulse_ctl(input bit s, input bit p, input bit with_pps);
        @(posedge clk); #1;
        start = s; stop = p; pps = with_pps;
        @(posedge clk); #1;
        start = 0; stop = 0; pps = 0;
        if (p) m_armed = 0;
        else if (s) m_armed = 1;
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (bytes_in_frame < n && t < 2000) begin @(negedge clk); #1; t++; end
        chk("wait_bytes_timeout", (t < 2000), 1);
    endtask

    // Issue a PPS with the current channel inputs, then disturb the inputs once the snapshot is taken.
    task automatic report(input logic [1:0] en, input bit stop_mid, input bit chk_lat);
        for (int c = 0; c < 2; c++) begin
            s_car[c] = car[c]; s_prn[c] = prn[c]; s_phs[c] = phs[c]; s_re[c] = re[c]; s_im[c] = im[c];
        end
        ch_en = en;
        if (m_armed && en != 2'b00) begin
            if (en[0]) push_frame(0, 0);
            if (en[1] && !(en[0] && stop_mid)) push_frame(1, en[0]);
        end
        pulse_ctl(0, 0, 1);
        if (chk_lat) begin
            @(negedge clk);
            chk("lat_snap_valid", tx_valid, 0);
            chk("lat_snap_busy", tx_busy, 1);
            @(negedge clk);
            chk("lat_valid", tx_valid, 1);
            chk("lat_hdr", tx_byte, HDR);
        end else begin
            @(posedge clk); #1;
        end
        scramble();
        if (stop_mid) begin
            wait_bytes(3);
            pulse_ctl(0, 1, 0);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((tx_busy || exp_q.size() != 0) && n < 4000) begin @(negedge clk); n++; end
        chk({name, "_drain"}, (n < 4000), 1);
        chk({name, "_queue"}, exp_q.size(), 0);
    endtask

    task automatic expect_idle(input string name);
        bit b = 0;
        repeat (8) begin @(negedge clk); b = b | tx_busy; end
        chk(name, b, 0);
    endtask

    // Ready driver
    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = 1'($urandom_range(0, 1));
            default: ready = 1'b0;
        endcase
    end

    // Monitor
    initial begin
        bit         prev_stall = 0, prev_valid = 0, done_seen = 0;
        logic [7:0] prev_byte = 8'h00;
        int         low_run = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0; prev_valid = 0; done_seen = 0; low_run = 0; bytes_in_frame = 0;
            end else begin
                if (tx_ovf) ovf_seen++;
                if (prev_stall) begin
                    chk("hold_valid", tx_valid, 1);
                    chk("hold_byte", tx_byte, prev_byte);
                end
                if (tx_valid && !prev_valid && done_seen && exp_q.size() != 0) begin
                    if (exp_q[0].follows) chk("gap_exact", low_run, GAP_CYC);
                    else                  chk("gap_min", (low_run >= GAP_CYC), 1);
                end
                if (!tx_valid) low_run++;
                if (tx_valid && ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_byte: got %0h, no byte expected", tx_byte);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", tx_byte, e.d);
                        chk("frame_done", tx_frame_done, e.last);
                    end
                    bytes_in_frame++;
                    if (tx_frame_done) begin
                        frames_seen++; bytes_in_frame = 0; done_seen = 1; low_run = 0;
                    end
                end else begin
                    chk("frame_done_idle", tx_frame_done, 0);
                end
                prev_stall = tx_valid && !ready;
                prev_byte  = tx_byte;
                prev_valid = tx_valid;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        for (int c = 0; c < 2; c++) begin
            car[c] = '0; prn[c] = '0; phs[c] = '0; re[c] = '0; im[c] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", tx_valid, 0);
        chk("rst_byte", tx_byte, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_frame_done, 0);
        chk("rst_ovf", tx_ovf, 0);
        chk("rst_ovf_cnt", tx_ovf_cnt, 0);
        @(posedge clk); #1 rst = 0;

        // 1: both channels, always ready, fixed values
        car[0] = 32'h12345678; prn[0] = 32'h9ABCDEF0; phs[0] = 12'hABC; re[0] = 24'h123456; im[0] = 24'hFEDCBA;
        car[1] = 32'h0BADF00D; prn[1] = 32'hCAFEBABE; phs[1] = 12'h321; re[1] = 24'h800001; im[1] = 24'h7FFFFE;
        ready_mode = 0;
        pulse_ctl(1, 0, 0);
        f0 = frames_seen;
        report(2'b11, 0, 1);
        wait_idle("s1");
        chk("s1_frames", frames_seen - f0, 2);

        // 2: same values, random backpressure
        car[0] = 32'h12345678; prn[0] = 32'h9ABCDEF0; phs[0] = 12'hABC; re[0] = 24'h123456; im[0] = 24'hFEDCBA;
        car[1] = 32'h0BADF00D; prn[1] = 32'hCAFEBABE; phs[1] = 12'h321; re[1] = 24'h800001; im[1] = 24'h7FFFFE;
        ready_mode = 1;
        report(2'b11, 0, 0);
        wait_idle("s2");
        for (int r = 0; r < 3; r++) begin
            scramble();
            report(2'b11, 0, 0);
            wait_idle("s2r");
        end

        // 3: overrun during BOC frame, then saturation
        scramble();
        report(2'b11, 0, 0);
        wait_bytes(5);
        pulse_ctl(0, 0, 1);
        exp_ovf++; ovf_events++;
        chk("ovf_cnt_1", tx_ovf_cnt, exp_ovf);
        wait_idle("s3a");
        ready_mode = 2;
        scramble();
        report(2'b11, 0, 0);
        repeat (256) begin
            pulse_ctl(0, 0, 1);
            ovf_events++;
            exp_ovf = (exp_ovf < 255) ? exp_ovf + 1 : 255;
        end
        chk("ovf_cnt_sat", tx_ovf_cnt, exp_ovf);
        chk("ovf_cnt_ff", tx_ovf_cnt, 8'hFF);
        ready_mode = 0;
        wait_idle("s3b");

        // 4: TMBOC only, then no channels
        ready_mode = 1;
        scramble();
        report(2'b10, 0, 0);
        wait_idle("s4");
        ch_en = 2'b00;
        pulse_ctl(0, 0, 1);
        expect_idle("s4_en00_idle");

        // 5: reset mid-frame
        scramble();
        report(2'b11, 0, 0);
        wait_bytes(7);
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("midrst_valid", tx_valid, 0);
        chk("midrst_byte", tx_byte, 0);
        chk("midrst_busy", tx_busy, 0);
        chk("midrst_ovf_cnt", tx_ovf_cnt, 0);
        exp_q.delete();
        m_armed = 0; exp_ovf = 0;
        @(posedge clk); #1 rst = 0;
        ready_mode = 0;
        ch_en = 2'b11;
        pulse_ctl(0, 0, 1);
        expect_idle("s5_unarmed_idle");
        pulse_ctl(1, 0, 0);
        scramble();
        report(2'b01, 0, 0);
        wait_idle("s5");

        // 6: arming corner cases and stop mid-report
        pulse_ctl(0, 1, 0);
        ch_en = 2'b11;
        pulse_ctl(0, 0, 1);
        expect_idle("s6_disarmed_idle");
        pulse_ctl(1, 1, 0);
        pulse_ctl(0, 0, 1);
        expect_idle("s6_startstop_idle");
        pulse_ctl(1, 0, 1);
        expect_idle("s6_start_pps_idle");
        ready_mode = 1;
        scramble();
        report(2'b11, 0, 0);
        wait_idle("s6a");
        scramble();
        report(2'b11, 1, 0);
        wait_idle("s6b");
        chk("ovf_pulses", ovf_seen, ovf_events);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
